// File: rtl/decoder_strobe_seq.sv
// Sequenced one-hot strobe decoder: SINGLE or SWEEP walks, each index held HOLD enabled cycles.
// Optional DECODER_STROBE_DOWN_EN adds a 'down' input that makes SWEEP walk toward index 0.
module decoder_strobe_seq #(
    parameter int N    = 5,
    parameter int HOLD = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N-1:0]      in,
    input  logic              sweep,
`ifdef DECODER_STROBE_DOWN_EN
    input  logic              down,
`endif
    output logic [2**N-1:0]   out,
    output logic              busy,
    output logic              done
);

    localparam int            CW      = $clog2(HOLD + 1);
    localparam logic [CW-1:0] HOLD_M1 = CW'(HOLD - 1);
    localparam logic [N-1:0]  LAST    = '1;

    typedef enum logic {IDLE, STROBE} state_t;

    state_t        state;
    logic [N-1:0]  addr;
    logic [CW-1:0] hold_cnt;
    logic          mode;
    logic          at_end;
    logic [N-1:0]  addr_nxt;

`ifdef DECODER_STROBE_DOWN_EN
    logic          dir_dn;
    assign at_end   = dir_dn ? (addr == '0) : (addr == LAST);
    assign addr_nxt = dir_dn ? (addr - N'(1)) : (addr + N'(1));
`else
    assign at_end   = (addr == LAST);
    assign addr_nxt = addr + N'(1);
`endif

    assign in_ready = (state == IDLE);
    assign busy     = (state == STROBE);

    always_comb begin
        out = '0;
        if (state == STROBE && ena)
            out[addr] = 1'b1;
    end

    // Sequencer: all progress is gated by ena except request acceptance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            addr     <= '0;
            hold_cnt <= '0;
            mode     <= 1'b0;
            done     <= 1'b0;
`ifdef DECODER_STROBE_DOWN_EN
            dir_dn   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        addr     <= in;
                        mode     <= sweep;
                        hold_cnt <= HOLD_M1;
                        state    <= STROBE;
`ifdef DECODER_STROBE_DOWN_EN
                        dir_dn   <= down;
`endif
                    end
                end
                STROBE: begin
                    if (ena) begin
                        if (hold_cnt != '0) begin
                            hold_cnt <= hold_cnt - CW'(1);
                        end else if (!mode || at_end) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end else begin
                            addr     <= addr_nxt;
                            hold_cnt <= HOLD_M1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_decoder_strobe_seq.sv
// Bench for decoder_strobe_seq: three parameterisations share stimulus; a schedule model checks all.
module tb_decoder_strobe_seq;

    localparam int MN [3] = '{3, 3, 2};
    localparam int MH [3] = '{2, 1, 3};

    logic       clk = 1'b0;
    logic       rst, ena, in_valid, sweep, dn_in;
    logic [2:0] idx;
    logic [7:0] out0, out1;
    logic [3:0] out2;
    logic       rdy0, rdy1, rdy2, busy0, busy1, busy2, done0, done1, done2;

    int n_chk  = 0;
    int n_fail = 0;

    bit act  [3];
    bit dexp [3];
    bit mdn  [3];
    int k    [3];
    int c    [3];
    int tot  [3];

    typedef struct {
        bit         e;
        bit         v;
        bit         s;
        logic [2:0] x;
        logic [7:0] o;
        bit         b;
        bit         d;
    } vec_t;

    vec_t tbl [23];

    always #5 clk = ~clk;

    decoder_strobe_seq #(.N(3), .HOLD(2)) u0 (
        .clk(clk), .rst(rst), .ena(ena), .in_valid(in_valid), .in_ready(rdy0),
        .in(idx), .sweep(sweep),
`ifdef DECODER_STROBE_DOWN_EN
        .down(dn_in),
`endif
        .out(out0), .busy(busy0), .done(done0)
    );

    decoder_strobe_seq #(.N(3), .HOLD(1)) u1 (
        .clk(clk), .rst(rst), .ena(ena), .in_valid(in_valid), .in_ready(rdy1),
        .in(idx), .sweep(sweep),
`ifdef DECODER_STROBE_DOWN_EN
        .down(dn_in),
`endif
        .out(out1), .busy(busy1), .done(done1)
    );

    decoder_strobe_seq #(.N(2), .HOLD(3)) u2 (
        .clk(clk), .rst(rst), .ena(ena), .in_valid(in_valid), .in_ready(rdy2),
        .in(idx[1:0]), .sweep(sweep),
`ifdef DECODER_STROBE_DOWN_EN
        .down(dn_in),
`endif
        .out(out2), .busy(busy2), .done(done2)
    );

    task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, a, e, $time);
        end
    endtask

    function automatic int cur_idx(int i);
        return mdn[i] ? (k[i] - c[i] / MH[i]) : (k[i] + c[i] / MH[i]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            act[i]  = 1'b0;
            dexp[i] = 1'b0;
        end
    endtask

    task automatic check_all();
        logic [7:0] o  [3];
        logic [2:0] fl [3];
        logic [7:0] eo;
        o[0]  = out0;
        o[1]  = out1;
        o[2]  = {4'h0, out2};
        fl[0] = {busy0, rdy0, done0};
        fl[1] = {busy1, rdy1, done1};
        fl[2] = {busy2, rdy2, done2};
        for (int i = 0; i < 3; i++) begin
            eo = (act[i] && ena) ? 8'(1 << cur_idx(i)) : 8'h00;
            chk($sformatf("model_out[%0d]", i), 32'(o[i]), 32'(eo));
            chk($sformatf("model_flags[%0d]", i), 32'(fl[i]), 32'({act[i], !act[i], dexp[i]}));
        end
    endtask

    // One clock: model advances on the rising edge, outputs compared on the falling edge
    task automatic cycle();
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            dexp[i] = 1'b0;
            if (rst) begin
                act[i] = 1'b0;
            end else if (!act[i]) begin
                if (in_valid) begin
                    act[i] = 1'b1;
                    k[i]   = int'(idx) % (1 << MN[i]);
                    c[i]   = 0;
                    mdn[i] = sweep && dn_in;
                    if (!sweep)
                        tot[i] = MH[i];
                    else if (dn_in)
                        tot[i] = (k[i] + 1) * MH[i];
                    else
                        tot[i] = ((1 << MN[i]) - k[i]) * MH[i];
                end
            end else if (ena) begin
                c[i]++;
                if (c[i] == tot[i]) begin
                    act[i]  = 1'b0;
                    dexp[i] = 1'b1;
                end
            end
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic wait_idle();
        in_valid = 1'b0;
        ena      = 1'b1;
        for (int t = 0; t < 64; t++) begin
            if (rdy0 && rdy1 && rdy2)
                break;
            cycle();
        end
        chk("idle_wait", 32'({rdy0, rdy1, rdy2}), 32'h7);
    endtask

    initial begin
        rst = 1'b1; ena = 1'b1; in_valid = 1'b0; sweep = 1'b0; dn_in = 1'b0; idx = 3'd0;
        model_reset();

        tbl = '{
            '{1'b1, 1'b1, 1'b0, 3'd0, 8'h01, 1'b1, 1'b0},
            '{1'b1, 1'b0, 1'b0, 3'd0, 8'h01, 1'b1, 1'b0},
            '{1'b0, 1'b1, 1'b1, 3'd3, 8'h00, 1'b1, 1'b0},
            '{1'b0, 1'b1, 1'b1, 3'd3, 8'h00, 1'b1, 1'b0},
            '{1'b0, 1'b1, 1'b1, 3'd3, 8'h00, 1'b1, 1'b0},
            '{1'b0, 1'b1, 1'b1, 3'd3, 8'h00, 1'b1, 1'b0},
            '{1'b1, 1'b1, 1'b0, 3'd7, 8'h00, 1'b0, 1'b1},
            '{1'b1, 1'b1, 1'b0, 3'd7, 8'h80, 1'b1, 1'b0},
            '{1'b1, 1'b0, 1'b0, 3'd0, 8'h80, 1'b1, 1'b0},
            '{1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1},
            '{1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0},
            '{1'b1, 1'b1, 1'b1, 3'd5, 8'h20, 1'b1, 1'b0},
            '{1'b1, 1'b0, 1'b0, 3'd0, 8'h20, 1'b1, 1'b0},
            '{1'b1, 1'b0, 1'b0, 3'd0, 8'h40, 1'b1, 1'b0},
            '{1'b1, 1'b0, 1'b0, 3'd0, 8'h40, 1'b1, 1'b0},
            '{1'b1, 1'b0, 1'b0, 3'd0, 8'h80, 1'b1, 1'b0},
            '{1'b1, 1'b0, 1'b0, 3'd0, 8'h80, 1'b1, 1'b0},
            '{1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1},
            '{1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0},
            '{1'b1, 1'b1, 1'b1, 3'd7, 8'h80, 1'b1, 1'b0},
            '{1'b1, 1'b0, 1'b0, 3'd0, 8'h80, 1'b1, 1'b0},
            '{1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1},
            '{1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0}
        };

        @(negedge clk);
        check_all();
        chk("reset_flags0", 32'({busy0, rdy0, done0}), 32'h2);
        rst = 1'b0;
        cycle();

        for (int r = 0; r < 23; r++) begin
            ena      = tbl[r].e;
            in_valid = tbl[r].v;
            sweep    = tbl[r].s;
            idx      = tbl[r].x;
            cycle();
            chk($sformatf("tbl_out[%0d]", r), 32'(out0), 32'(tbl[r].o));
            chk($sformatf("tbl_flags[%0d]", r), 32'({busy0, rdy0, done0}),
                32'({tbl[r].b, !tbl[r].b, tbl[r].d}));
        end

        wait_idle();
        in_valid = 1'b1; sweep = 1'b0; idx = 3'd5;
        cycle();
        in_valid = 1'b0;
        chk("single_out", 32'(out1), 32'h20);
        chk("single_busy", 32'(busy1), 32'h1);
        cycle();
        chk("single_done", 32'({out1, done1, rdy1}), 32'({8'h00, 1'b1, 1'b1}));

        wait_idle();
        in_valid = 1'b1; sweep = 1'b1; idx = 3'd1;
        cycle();
        in_valid = 1'b0;
        for (int j = 0; j < 9; j++) begin
            if (j > 0)
                cycle();
            chk($sformatf("sweep_out[%0d]", j), 32'(out2), 32'(4'b0010 << (j / 3)));
            chk($sformatf("sweep_rdy[%0d]", j), 32'({rdy2, busy2}), 32'h1);
        end
        cycle();
        chk("sweep_done", 32'({out2, done2}), 32'h1);

`ifdef DECODER_STROBE_DOWN_EN
        wait_idle();
        in_valid = 1'b1; sweep = 1'b1; dn_in = 1'b1; idx = 3'd2;
        cycle();
        in_valid = 1'b0; dn_in = 1'b0;
        for (int j = 0; j < 3; j++) begin
            if (j > 0)
                cycle();
            chk($sformatf("down_out[%0d]", j), 32'(out1), 32'(8'h04 >> j));
        end
        cycle();
        chk("down_done", 32'({out1, done1}), 32'h1);
`endif

        wait_idle();
        in_valid = 1'b1; sweep = 1'b1; idx = 3'd2;
        cycle();
        in_valid = 1'b0;
        cycle();
        cycle();
        rst = 1'b1;
        #1;
        model_reset();
        chk("async_rst0", 32'({out0, busy0, rdy0, done0}), 32'h2);
        check_all();
        cycle();
        rst = 1'b0;
        for (int j = 0; j < 3; j++) begin
            cycle();
            chk($sformatf("rst_nodone[%0d]", j), 32'({done0, rdy0}), 32'h1);
        end

        for (int n = 0; n < 3000; n++) begin
            rst      = ($urandom_range(0, 199) == 0);
            ena      = ($urandom_range(0, 9) != 0);
            in_valid = ($urandom_range(0, 2) == 0);
            sweep    = 1'($urandom_range(0, 1));
            idx      = 3'($urandom_range(0, 7));
`ifdef DECODER_STROBE_DOWN_EN
            dn_in    = 1'($urandom_range(0, 1));
`endif
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/decoder_strobe_seq.md
Name: decoder_strobe_seq

Overview:
Parametrised, sequential successor to the fixed-width combinational decoders. Accepts an N-bit index via valid/ready and drives a one-hot strobe on 2**N outputs for HOLD cycles per index. Two modes: SINGLE (strobe one index) and SWEEP (strobe every index from the accepted one up to 2**N-1). Used for register-file write-enable fan-out and for sequenced init/clear walks over banked resources.

Parameters:
N, 5, index width; output width is 2**N; legal range 1..8
HOLD, 1, cycles each one-hot strobe is held; legal range >= 1; counter width $clog2(HOLD+1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
ena  input  1  global enable; low forces out to zero and pauses sequencing
in_valid  input  1  request valid
in_ready  output  1  block can accept a request
in  input  N  start index
sweep  input  1  mode, sampled with the request: 0 = SINGLE, 1 = SWEEP
out  output  2**N  one-hot strobe, all-zero when inactive
busy  output  1  high while in STROBE
done  output  1  one-cycle pulse when a request completes

Behaviour:
- Reset (async, immediate): state=IDLE, addr=0, hold_cnt=0, mode=0. Outputs: out=0, busy=0, done=0, in_ready=1. Reset asserted mid-sequence aborts with no done pulse.
- FSM states: IDLE and STROBE.
- IDLE:
  - in_ready=1, busy=0, out=0.
  - Accept when in_valid && in_ready: addr<=in, mode<=sweep, hold_cnt<=HOLD-1, go to STROBE.
  - Acceptance does not depend on ena.
- STROBE:
  - in_ready=0, busy=1.
  - out = ena ? (1<<addr) : 0. Combinational from registered addr/state and ena. Exactly one bit high, or none.
  - If ena=1 and hold_cnt!=0: hold_cnt decrements.
  - If ena=1 and hold_cnt==0:
    - SINGLE, or SWEEP with addr==2**N-1: go to IDLE and assert done for 1 cycle, coincident with the first IDLE cycle.
    - Otherwise: addr<=addr+1, hold_cnt<=HOLD-1, stay in STROBE.
  - If ena=0: addr, hold_cnt and state are frozen. Only cycles with ena=1 count toward HOLD.
- Latency: the strobe appears in the cycle after acceptance.
  - SINGLE: HOLD enabled cycles.
  - SWEEP from index k: (2**N-k)*HOLD enabled cycles.
- Back-to-back: the earliest next acceptance is the done cycle (IDLE with in_ready=1). There is no bubble beyond that cycle.
- Wrap-around: addr never wraps. SWEEP terminates at 2**N-1. SWEEP from 2**N-1 behaves like SINGLE.
- in_valid while busy is ignored. in, sweep and in_valid may change freely while in_ready=0.
- done and in_valid in the same cycle: the new request is accepted, and done still pulses.
- All arithmetic is unsigned. The addr increment is N bits wide and guarded by the terminal check, so no overflow is possible.

Optional Feature:
Macro DECODER_STROBE_DOWN_EN.
- Defined: adds input port down (1 bit), sampled with the request.
  - SWEEP with down=1 decrements addr and terminates after index 0.
  - SWEEP from index 0 with down=1 behaves like SINGLE.
  - Latency is (k+1)*HOLD.
  - down is ignored in SINGLE mode.
- Undefined: no down port; SWEEP always counts upward. All other behaviour is identical.

Test Plan:
- Reset: assert rst mid-SWEEP (N=3, HOLD=2, in=2). Expect out=0, busy=0, in_ready=1 asynchronously and no done pulse. After release, state is IDLE.
- SINGLE: N=3, HOLD=1, in=5, ena=1, one-cycle in_valid. Expect out=8'b0010_0000 for exactly 1 cycle starting the cycle after acceptance, then done=1 for 1 cycle with out=0.
- SWEEP with hold: N=2, HOLD=3, in=1. Expect out=0010 x3, 0100 x3, 1000 x3 cycles, then done. 9 busy cycles total; in_ready=0 throughout.
- ena pause: N=3, HOLD=2, in=0, SINGLE; drop ena for 4 cycles after the first strobe cycle. Expect out=0 while ena=0 and busy=1 held; strobe resumes for 1 more cycle, then done (6 busy cycles).
- Back-to-back: second request in=7, sweep=0 presented with in_valid held high. Expect it accepted in the done cycle of the first, and its strobe starting the next cycle. Requests driven while busy are ignored.
- With DECODER_STROBE_DOWN_EN: N=2, HOLD=1, in=2, sweep=1, down=1. Expect out=0100, 0010, 0001 on consecutive cycles, then done.
